// File: rtl/lcd_host_driver.sv
// Host-side driver for the 6x6-image / 3x3-window LCD controller: one op at a time, optional ROM stream, 3x3 window collect.
// Optional macro LCD_TIMEOUT_EN adds a no-response watchdog (TIMEOUT cycles from command issue).
module lcd_host_driver #(
    parameter int DW      = 8,
    parameter int IMG_PIX = 36,
    parameter int WIN_PIX = 9
`ifdef LCD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op_code,
    output logic                  op_ready,
    output logic [5:0]            img_addr,
    output logic                  img_rd,
    input  logic [DW-1:0]         img_rdata,
    output logic [2:0]            lcd_cmd,
    output logic                  lcd_cmd_valid,
    output logic [DW-1:0]         lcd_datain,
    input  logic                  lcd_busy,
    input  logic [DW-1:0]         lcd_dataout,
    input  logic                  lcd_output_valid,
    output logic [WIN_PIX*DW-1:0] win_data,
    output logic                  win_valid,
    output logic                  err,
    output logic [1:0]            debug_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LOAD    = 2'd2,
        COLLECT = 2'd3
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [5:0] LOAD_LAST  = 6'(IMG_PIX);
    localparam logic [3:0] SLOT_LAST  = 4'(WIN_PIX - 1);

    state_t        state, state_nx;
    logic [2:0]    code_q;
    logic [5:0]    load_cnt;
    logic [3:0]    slot_cnt;
    logic [DW-1:0] shadow [0:WIN_PIX-2];
    logic          accept, legal, capture, timeout_hit;

    // Handshake: an op is taken on a rising edge where op_valid and op_ready are both high.
    assign accept      = op_valid & op_ready;
    assign legal       = (op_code <= 3'd5);
    assign capture     = (state == COLLECT) & lcd_output_valid;
    assign debug_state = state;

`ifdef LCD_TIMEOUT_EN
    localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);
    logic [6:0] tmo_cnt;

    // Counts from the ISSUE cycle (value 0) and saturates; only matters until slot 0 is filled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || capture) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 7'd1;
        end
    end

    assign timeout_hit = (state == LOAD || state == COLLECT) && (slot_cnt == 4'd0)
                         && !capture && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        op_ready      = 1'b0;
        lcd_cmd_valid = 1'b0;
        lcd_cmd       = '0;
        img_rd        = 1'b0;
        img_addr      = '0;
        lcd_datain    = '0;
        case (state)
            IDLE: begin
                op_ready = ~lcd_busy & ~reset;
                if (op_valid && !lcd_busy && !reset && legal) state_nx = ISSUE;
            end
            ISSUE: begin
                lcd_cmd_valid = 1'b1;
                lcd_cmd       = code_q;
                if (code_q == OP_LOAD) begin
                    img_rd   = 1'b1;
                    state_nx = LOAD;
                end else begin
                    state_nx = COLLECT;
                end
            end
            LOAD: begin
                // ROM data arrives one cycle after its read, so pixel k-1 passes through in cycle k.
                lcd_datain = img_rdata;
                if (load_cnt != LOAD_LAST) begin
                    img_rd   = 1'b1;
                    img_addr = load_cnt;
                end else begin
                    state_nx = COLLECT;
                end
                if (timeout_hit) state_nx = IDLE;
            end
            COLLECT: begin
                if (capture && slot_cnt == SLOT_LAST) state_nx = IDLE;
                else if (timeout_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            code_q    <= '0;
            load_cnt  <= '0;
            slot_cnt  <= '0;
            win_data  <= '0;
            win_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            win_valid <= 1'b0;
            err       <= timeout_hit;
            if (state == IDLE && accept) begin
                if (legal) code_q <= op_code;
                else       err    <= 1'b1;
            end
            if (state == IDLE) begin
                load_cnt <= '0;
                slot_cnt <= '0;
            end else if (state == ISSUE) begin
                load_cnt <= 6'd1;
                slot_cnt <= '0;
            end else if (state == LOAD && load_cnt != LOAD_LAST) begin
                load_cnt <= load_cnt + 6'd1;
            end
            if (capture) begin
                if (slot_cnt == SLOT_LAST) begin
                    // Publish the whole window at once so partial captures never show.
                    for (int i = 0; i < WIN_PIX - 1; i++) win_data[i*DW +: DW] <= shadow[i];
                    win_data[(WIN_PIX-1)*DW +: DW] <= lcd_dataout;
                    win_valid <= 1'b1;
                end else begin
                    slot_cnt <= slot_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture && slot_cnt != SLOT_LAST) shadow[slot_cnt[2:0]] <= lcd_dataout;
    end

endmodule
